// File: rtl/i2c_pkg.sv
// Shared I2C pad-conditioning defaults and the event payload used by the line conditioner.
package i2c_pkg;

    localparam int unsigned I2C_SYNC_STAGES_DEF   = 2;
    localparam int unsigned I2C_FILTER_CYCLES_DEF = 4;
    localparam int unsigned I2C_BUS_IDLE_DEF      = 64;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start_det;
        logic stop_det;
    } i2c_events_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line synchroniser chain followed by a stable-level counter that rejects short pulses.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
    parameter int unsigned FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pad_in,
    output logic filt
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   sync_level;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign filt       = filt_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        cnt_d  = '0;
        filt_d = filt_q;
        // Level only moves after FILTER_CYCLES consecutive disagreeing samples.
        if (sync_level != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/i2c_line_conditioner.sv
// Pad-side I2C front end: filtered SDA/SCL, bus condition pulses, bus-busy tracking and
// registered open-drain pull-down enables.
module i2c_line_conditioner
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = I2C_SYNC_STAGES_DEF,
    parameter int unsigned FILTER_CYCLES   = I2C_FILTER_CYCLES_DEF,
    parameter int unsigned BUS_IDLE_CYCLES = I2C_BUS_IDLE_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sda_pad_in,
    input  logic scl_pad_in,
    input  logic core_sda_out,
    input  logic core_scl_out,
    output logic sda_oe,
    output logic scl_oe,
    output logic sda_filt,
    output logic scl_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    localparam int unsigned IDLE_W = $clog2(BUS_IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(BUS_IDLE_CYCLES - 1);

    i2c_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .pad_in (sda_pad_in),
        .filt   (sda_filt)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .pad_in (scl_pad_in),
        .filt   (scl_filt)
    );

    logic              sda_q, sda_d;
    logic              scl_q, scl_d;
    i2c_events_t       evt_q, evt_d;
    logic              busy_q, busy_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_oe_q, scl_oe_d;
    logic              idle_c;

    always_comb begin
        sda_d      = sda_filt;
        scl_d      = scl_filt;
        sda_oe_d   = ~core_sda_out;
        scl_oe_d   = ~core_scl_out;
        idle_cnt_d = '0;
        busy_d     = busy_q;
        idle_c     = busy_q & sda_filt & scl_filt;

        // START/STOP need SCL high on both sides of the SDA edge.
        evt_d.scl_rise  = scl_filt & ~scl_q;
        evt_d.scl_fall  = ~scl_filt & scl_q;
        evt_d.start_det = sda_q & ~sda_filt & scl_q & scl_filt;
        evt_d.stop_det  = ~sda_q & sda_filt & scl_q & scl_filt;

        if (idle_c) begin
            idle_cnt_d = (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        end

        // Idle timeout recovers from a lost STOP without emitting a stop pulse.
        if (evt_d.start_det) begin
            busy_d = 1'b1;
        end else if (evt_d.stop_det) begin
            busy_d = 1'b0;
        end else if (idle_c && (idle_cnt_q == IDLE_LAST)) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            evt_q      <= '0;
            busy_q     <= 1'b0;
            idle_cnt_q <= '0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            sda_q      <= sda_d;
            scl_q      <= scl_d;
            evt_q      <= evt_d;
            busy_q     <= busy_d;
            idle_cnt_q <= idle_cnt_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
        end
    end

    assign scl_rise  = evt_q.scl_rise;
    assign scl_fall  = evt_q.scl_fall;
    assign start_det = evt_q.start_det;
    assign stop_det  = evt_q.stop_det;
    assign bus_busy  = busy_q;
    assign sda_oe    = sda_oe_q;
    assign scl_oe    = scl_oe_q;

    a_core_known: assert property (@(posedge clk) disable iff (!n_rst)
        !$isunknown({core_sda_out, core_scl_out}));

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Self-checking bench for i2c_line_conditioner: vector table, directed corner sequences and
// randomized pads checked against a window/run-length reference model.
module tb_i2c_line_conditioner;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int IDLE = 64;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic sda_pad_in = 1'b1;
    logic scl_pad_in = 1'b1;
    logic core_sda_out = 1'b1;
    logic core_scl_out = 1'b1;
    logic sda_oe, scl_oe, sda_filt, scl_filt;
    logic scl_rise, scl_fall, start_det, stop_det, bus_busy;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    i2c_line_conditioner #(
        .SYNC_STAGES     (SYNC),
        .FILTER_CYCLES   (FILT),
        .BUS_IDLE_CYCLES (IDLE)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sda_pad_in   (sda_pad_in),
        .scl_pad_in   (scl_pad_in),
        .core_sda_out (core_sda_out),
        .core_scl_out (core_scl_out),
        .sda_oe       (sda_oe),
        .scl_oe       (scl_oe),
        .sda_filt     (sda_filt),
        .scl_filt     (scl_filt),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy)
    );

    // Reference model: a level is accepted once the last FILT synchronised samples all disagree
    // with it; busy times out after IDLE consecutive cycles of both lines high.
    bit q_sda[$];
    bit q_scl[$];
    bit m_sda, m_scl, m_sda_p, m_scl_p;
    bit m_rise, m_fall, m_start, m_stop, m_busy, m_sda_oe, m_scl_oe;
    int m_run;

    function automatic bit settle(input bit q[$], input bit cur);
        bit all_diff = 1'b1;
        for (int i = 0; i < FILT; i++) if (q[i] == cur) all_diff = 1'b0;
        return all_diff ? !cur : cur;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_sda.delete();
            q_scl.delete();
            for (int i = 0; i < SYNC + FILT; i++) begin
                q_sda.push_back(1'b1);
                q_scl.push_back(1'b1);
            end
            m_sda = 1; m_scl = 1; m_sda_p = 1; m_scl_p = 1;
            m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
            m_busy = 0; m_sda_oe = 0; m_scl_oe = 0; m_run = 0;
        end else begin
            q_sda.push_back(sda_pad_in);
            void'(q_sda.pop_front());
            q_scl.push_back(scl_pad_in);
            void'(q_scl.pop_front());
            m_rise  = m_scl & !m_scl_p;
            m_fall  = !m_scl & m_scl_p;
            m_start = m_sda_p & !m_sda & m_scl_p & m_scl;
            m_stop  = !m_sda_p & m_sda & m_scl_p & m_scl;
            if (m_busy && m_sda && m_scl) m_run++; else m_run = 0;
            if (m_start) m_busy = 1;
            else if (m_stop || m_run == IDLE) m_busy = 0;
            m_sda_p  = m_sda;
            m_scl_p  = m_scl;
            m_sda    = settle(q_sda, m_sda);
            m_scl    = settle(q_scl, m_scl);
            m_sda_oe = !core_sda_out;
            m_scl_oe = !core_scl_out;
        end
    end

    function automatic logic [8:0] outs();
        return {sda_filt, scl_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy, sda_oe, scl_oe};
    endfunction

    function automatic logic [8:0] model_outs();
        return {m_sda, m_scl, m_rise, m_fall, m_start, m_stop, m_busy, m_sda_oe, m_scl_oe};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    int  c_rise, c_fall, c_start, c_stop;
    bit  busy_low_seen, sda_low_seen;

    task automatic clr();
        c_rise = 0; c_fall = 0; c_start = 0; c_stop = 0;
        busy_low_seen = 0; sda_low_seen = 0;
    endtask

    // Advance n clocks; sample 1ns after each rising edge and accumulate pulse counts.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            c_rise  += int'(scl_rise);
            c_fall  += int'(scl_fall);
            c_start += int'(start_det);
            c_stop  += int'(stop_det);
            if (bus_busy !== 1'b1) busy_low_seen = 1;
            if (sda_filt !== 1'b1) sda_low_seen = 1;
        end
    endtask

    task automatic pads(input logic s, input logic c);
        sda_pad_in = s;
        scl_pad_in = c;
    endtask

    typedef struct {
        logic       sda;
        logic       scl;
        logic       csda;
        logic       cscl;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int hs, hc;

        // {sda_filt, scl_filt, rise, fall, start, stop, busy, sda_oe, scl_oe}
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 9'b11_0000_0_00};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'b01_0000_1_00};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b00_0000_1_00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 9'b10_0000_1_10};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'b11_0000_1_01};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'b01_0000_1_00};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 9'b11_0000_0_00};

        clr();
        cyc(3);
        chk("reset_outputs", 32'(outs()), 32'(9'b11_0000_0_00));
        n_rst = 1'b1;
        cyc(2);

        for (int i = 0; i < 7; i++) begin
            pads(vecs[i].sda, vecs[i].scl);
            core_sda_out = vecs[i].csda;
            core_scl_out = vecs[i].cscl;
            cyc(10);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Glitch rejection and filter latency.
        clr();
        pads(1'b0, 1'b1);
        cyc(3);
        pads(1'b1, 1'b1);
        cyc(10);
        chk("glitch3_rejected", 32'(sda_low_seen), 32'd0);
        pads(1'b0, 1'b1);
        n = 0;
        while (sda_filt !== 1'b0 && n < 20) begin cyc(1); n++; end
        chk("filter_latency", n, 32'd6);
        pads(1'b1, 1'b1);
        cyc(12);
        chk("glitch_bus_idle", 32'(bus_busy), 32'd0);

        // START.
        clr();
        pads(1'b0, 1'b1);
        cyc(12);
        chk("start_count", c_start, 32'd1);
        chk("start_no_scl_edges", c_rise + c_fall, 32'd0);
        chk("start_busy", 32'(bus_busy), 32'd1);

        // Nine SCL clocks then STOP.
        clr();
        repeat (9) begin
            pads(1'b0, 1'b0); cyc(10);
            pads(1'b0, 1'b1); cyc(10);
        end
        chk("xfer_rise", c_rise, 32'd9);
        chk("xfer_fall", c_fall, 32'd9);
        chk("xfer_no_cond", c_start + c_stop, 32'd0);
        chk("xfer_busy_held", 32'(busy_low_seen), 32'd0);
        clr();
        pads(1'b1, 1'b1);
        cyc(12);
        chk("stop_count", c_stop, 32'd1);
        chk("stop_clears_busy", 32'(bus_busy), 32'd0);

        // Simultaneous SDA/SCL fall is not a START.
        clr();
        pads(1'b0, 1'b0);
        cyc(12);
        chk("simul_fall", c_fall, 32'd1);
        chk("simul_no_start", c_start, 32'd0);
        chk("simul_busy", 32'(bus_busy), 32'd0);
        pads(1'b0, 1'b1); cyc(10);
        pads(1'b1, 1'b1); cyc(10);

        // Repeated START keeps the bus busy.
        pads(1'b0, 1'b1); cyc(10);
        pads(1'b0, 1'b0); cyc(10);
        pads(1'b1, 1'b0); cyc(10);
        clr();
        pads(1'b1, 1'b1); cyc(10);
        pads(1'b0, 1'b1); cyc(12);
        chk("rstart_count", c_start, 32'd1);
        chk("rstart_busy_held", 32'(busy_low_seen), 32'd0);
        pads(1'b1, 1'b1); cyc(12);
        chk("rstart_stop", 32'(bus_busy), 32'd0);

        // Idle timeout with no STOP.
        pads(1'b0, 1'b1); cyc(10);
        pads(1'b0, 1'b0); cyc(10);
        pads(1'b1, 1'b0); cyc(10);
        chk("timeout_pre_busy", 32'(bus_busy), 32'd1);
        clr();
        pads(1'b1, 1'b1);
        n = 0;
        while (!(sda_filt === 1'b1 && scl_filt === 1'b1) && n < 20) begin cyc(1); n++; end
        chk("timeout_lines_high", n, 32'd6);
        n = 0;
        while (bus_busy === 1'b1 && n < 200) begin cyc(1); n++; end
        chk("timeout_cycles", n, 32'(IDLE));
        cyc(10);
        chk("timeout_no_stop", c_stop, 32'd0);
        core_sda_out = 1'b0;
        chk("oe_before_edge", 32'(sda_oe), 32'd0);
        cyc(1);
        chk("oe_after_edge", 32'(sda_oe), 32'd1);

        // Async reset mid-transfer.
        pads(1'b0, 1'b1);
        cyc(12);
        chk("pre_reset_state", 32'({sda_filt, bus_busy, sda_oe}), 32'(3'b011));
        #3 n_rst = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'(9'b11_0000_0_00));
        pads(1'b1, 1'b1);
        core_sda_out = 1'b1;
        cyc(3);
        n_rst = 1'b1;
        cyc(2);

        // Randomized pads and controller outputs against the reference model.
        hs = 0;
        hc = 0;
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 299) == 0) begin
                pads(1'b1, 1'b1);
                hs = 90;
                hc = 90;
            end
            if (hs <= 0) begin
                sda_pad_in = 1'($urandom_range(0, 1));
                hs = int'($urandom_range(1, 10));
            end
            if (hc <= 0) begin
                scl_pad_in = 1'($urandom_range(0, 1));
                hc = int'($urandom_range(1, 10));
            end
            hs--;
            hc--;
            core_sda_out = 1'($urandom_range(0, 1));
            core_scl_out = 1'($urandom_range(0, 1));
            cyc(1);
            chk($sformatf("rand_cycle%0d", t), 32'(outs()), 32'(model_outs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
